pwm_core: RTL and testbench
===========================

Name: pwm_core

Overview:
Downstream stage of the 7-bit duty-cycle selector mux. Consumes the selected 7-bit duty word, expressed in percent, and produces the PWM output pin.
- Free-running period counter with a prescaled tick.
- Duty is double-buffered: a new duty word takes effect only at a period boundary, so there are no glitches when the mux selector changes.

Parameters:
PERIOD, 100, ticks per PWM period; legal 2..127; duty is interpreted against this value
PRESC_DIV, 1, clocks per counter tick; legal 1..255; used only when PWM_PRESCALER_EN is defined

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable, level-sensitive
duty  input  7  requested duty in ticks (percent at PERIOD=100), from selector mux output
pwm_out  output  1  PWM waveform, registered
period_end  output  1  one-clock pulse marking the start of each new period
duty_latched  output  7  duty value currently in effect (shadow register)

Behaviour:
- Reset, asynchronous on rst_n=0: cnt=PERIOD-1, duty_sh=0, pwm_out=0, period_end=0, prescaler count=0.
- tick: 1 every clock (feature off), or 1 every PRESC_DIV-th clock (feature on).
- Clamp: duty_eff = min(duty, PERIOD). Compare widths are 7 bits, unsigned.
- en=0, every clock:
  - cnt <= PERIOD-1, pwm_out <= 0, period_end <= 0.
  - duty_sh <= duty_eff.
  - Prescaler count cleared.
- en=1 and tick and cnt==PERIOD-1 (wrap):
  - cnt <= 0, duty_sh <= duty_eff.
  - pwm_out <= (duty_eff != 0).
  - period_end <= 1.
- en=1 and tick and cnt<PERIOD-1:
  - cnt <= cnt+1.
  - pwm_out <= (cnt+1 < duty_sh).
  - period_end <= 0.
- en=1 and no tick: all state held, except period_end <= 0.
- Result: pwm_out is high for exactly duty_sh ticks at the start of each period.
  - duty_sh=0: constantly low.
  - duty_sh=PERIOD: constantly high.
- First tick after en rises: wrap path, so the first period starts immediately with the current duty and period_end pulses.
- en falling mid-period: pwm_out=0 on the next clock; the partial period is abandoned.
- Duty change mid-period: ignored until the next wrap; duty_latched shows the value in effect.
- Duty > PERIOD, e.g. 101..127 at PERIOD=100: clamped, 100% duty.
- Reset mid-period: immediate return to reset values; no pulse on period_end.

Optional Feature:
PWM_PRESCALER_EN
- Defined: an 8-bit prescaler counts 0..PRESC_DIV-1. tick is asserted when the count equals PRESC_DIV-1, then the count wraps to 0. The count is cleared while en=0. PWM period = PERIOD*PRESC_DIV clocks.
- Undefined: tick=1 every clock, no prescaler logic, PRESC_DIV ignored. PWM period = PERIOD clocks.

Decomposition:
- Package pwm_pkg:
  - DUTY_W=7.
  - Default PERIOD=100 and PRESC_DIV=1.
  - Clamp helper function min(duty, PERIOD).
- One sub-module: pwm_presc, the tick generator (PRESC_DIV parameter, clk, rst_n, clr, tick out), instantiated only under PWM_PRESCALER_EN.

Test Plan:
- Reset, en=1, duty=25, PERIOD=100, feature off -> pwm_out high 25 clocks, low 75 clocks, repeating; period_end pulses every 100 clocks; duty_latched=25.
- duty=0, then duty=100, then duty=127 (each held for 2 periods) -> constant low; then constant high with duty_latched=100; then constant high with duty_latched=100.
- duty changed 25->60 at cnt=10 -> current period stays 25 high; next period 60 high; duty_latched changes only on the period_end cycle.
- en dropped at cnt=50 with duty=75 -> pwm_out=0 next clock; period_end=0. en re-raised -> period_end pulse and pwm_out high on the first clock, new period from cnt=0.
- PWM_PRESCALER_EN, PRESC_DIV=4, duty=10 -> pwm_out high 40 clocks, period 400 clocks.
- rst_n pulsed low at cnt=30 with pwm_out=1 -> pwm_out=0 asynchronously, duty_latched=0. After release -> a full period restarts at first tick.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, default parameters and the duty clamp helper for
// the PWM output stage.
//   DUTY_W        - width of the duty word and the period counter
//   PERIOD_DEF    - default ticks per PWM period
//   PRESC_DIV_DEF - default clocks per counter tick (prescaler builds only)
//   clamp_duty()  - min(duty, period), unsigned 7-bit
package pwm_pkg;

    localparam int DUTY_W        = 7;
    localparam int PERIOD_DEF    = 100;
    localparam int PRESC_DIV_DEF = 1;

    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] duty,
        input logic [DUTY_W-1:0] period
    );
        return (duty > period) ? period : duty;
    endfunction

endpackage

// File: rtl/pwm_presc.sv
// pwm_presc: tick generator for the PWM period counter.
// An 8-bit count runs 0..PRESC_DIV-1; tick is high on the clock where the
// count sits at PRESC_DIV-1, after which the count wraps to 0.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear of the count (held while the PWM is disabled)
//   tick  - one-clock enable for the period counter
module pwm_presc #(
    parameter int PRESC_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(PRESC_DIV - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign tick = !clr && (count == LAST);

endmodule

// File: rtl/pwm_core.sv
// pwm_core: PWM output stage fed by the duty-cycle selector mux.
// A free-running period counter (0..PERIOD-1) advances on each tick; the
// duty word is clamped to PERIOD and captured into a shadow register only at
// the period wrap (or continuously while disabled), so selector changes never
// produce a runt pulse.
// Optional build macro: PWM_PRESCALER_EN - when defined, ticks come from
// pwm_presc every PRESC_DIV clocks; otherwise the counter ticks every clock.
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   en           - run enable, level-sensitive
//   duty         - requested duty in ticks
//   pwm_out      - registered PWM waveform
//   period_end   - one-clock pulse on the first clock of each period
//   duty_latched - duty value currently in effect
module pwm_core
    import pwm_pkg::*;
#(
    parameter int PERIOD    = PERIOD_DEF,
    parameter int PRESC_DIV = PRESC_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_out,
    output logic              period_end,
    output logic [DUTY_W-1:0] duty_latched
);

    localparam logic [DUTY_W-1:0] PER  = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);

    if (PERIOD < 2 || PERIOD > 127) begin : g_bad_period
        $error("pwm_core: PERIOD must be within 2..127");
    end
    if (PRESC_DIV < 1 || PRESC_DIV > 255) begin : g_bad_presc
        $error("pwm_core: PRESC_DIV must be within 1..255");
    end

    logic              tick;
    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] cnt_nxt;
    logic [DUTY_W-1:0] duty_sh;
    logic [DUTY_W-1:0] duty_eff;

`ifdef PWM_PRESCALER_EN
    pwm_presc #(
        .PRESC_DIV (PRESC_DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!en),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign duty_eff = clamp_duty(duty, PER);
    // cnt never exceeds PERIOD-2 on this path, so the increment cannot wrap
    assign cnt_nxt  = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= LAST;
            duty_sh    <= '0;
            pwm_out    <= 1'b0;
            period_end <= 1'b0;
        end else if (!en) begin
            // parked at LAST so the first tick after enable wraps straight away
            cnt        <= LAST;
            duty_sh    <= duty_eff;
            pwm_out    <= 1'b0;
            period_end <= 1'b0;
        end else if (tick) begin
            if (cnt == LAST) begin
                cnt        <= '0;
                duty_sh    <= duty_eff;
                pwm_out    <= (duty_eff != '0);
                period_end <= 1'b1;
            end else begin
                cnt        <= cnt_nxt;
                pwm_out    <= (cnt_nxt < duty_sh);
                period_end <= 1'b0;
            end
        end else begin
            period_end <= 1'b0;
        end
    end

    assign duty_latched = duty_sh;

endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core: directed bench for pwm_core at PERIOD=100.
// Expected high/period lengths are hand-derived in ticks and scaled by the
// clocks-per-tick of the build (4 with PWM_PRESCALER_EN, else 1).
module tb_pwm_core;
    import pwm_pkg::*;

`ifdef PWM_PRESCALER_EN
    localparam int TK = 4;
`else
    localparam int TK = 1;
`endif
    localparam int BUDGET = 200 * TK + 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [DUTY_W-1:0] duty = '0;
    logic              pwm_out;
    logic              period_end;
    logic [DUTY_W-1:0] duty_latched;

    int n_vec = 0;
    int n_err = 0;

    pwm_core #(
        .PERIOD    (100),
        .PRESC_DIV (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .period_end   (period_end),
        .duty_latched (duty_latched)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // advance to the next negedge where period_end is high
    task automatic wait_pe(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_end && n < BUDGET);
        chk({tag, "_pe_seen"}, int'(period_end), 1);
    endtask

    // called at a period_end negedge; returns clocks to next period_end and
    // the number of those clocks with pwm_out high
    task automatic measure(output int len, output int high);
        len  = 0;
        high = 0;
        do begin
            if (pwm_out) high++;
            len++;
            @(negedge clk);
        end while (!period_end && len < BUDGET);
    endtask

    // clocks from now until period_end is seen
    task automatic clocks_to_pe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_end && n < BUDGET);
    endtask

    initial begin
        int len, high, n, last_lat;
        logic [DUTY_W-1:0] duty_tab [3];
        int                lat_tab  [3];
        int                high_tab [3];
        duty_tab = '{7'd0, 7'd100, 7'd127};
        lat_tab  = '{0, 100, 100};
        high_tab = '{0, 100 * TK, 100 * TK};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_pe", int'(period_end), 0);
        chk("rst_lat", int'(duty_latched), 0);

        // 25% duty
        rst_n = 1'b1;
        duty  = 7'd25;
        @(negedge clk);
        en = 1'b1;
        clocks_to_pe(n);
        chk("start_delay", n, TK);
        chk("start_pwm", int'(pwm_out), 1);
        chk("d25_lat", int'(duty_latched), 25);
        for (int i = 0; i < 2; i++) begin
            measure(len, high);
            chk("d25_len", len, 100 * TK);
            chk("d25_high", high, 25 * TK);
        end

        // 0, 100, clamped 127
        for (int k = 0; k < 3; k++) begin
            duty = duty_tab[k];
            wait_pe("dtab");
            chk("dtab_lat", int'(duty_latched), lat_tab[k]);
            for (int i = 0; i < 2; i++) begin
                measure(len, high);
                chk("dtab_len", len, 100 * TK);
                chk("dtab_high", high, high_tab[k]);
            end
        end

        // mid-period duty change 25 -> 60 at cnt=10
        duty = 7'd25;
        wait_pe("chg");
        chk("chg_lat0", int'(duty_latched), 25);
        len = 0; high = 0; last_lat = -1;
        do begin
            if (len == 10 * TK) duty = 7'd60;
            if (pwm_out) high++;
            last_lat = int'(duty_latched);
            len++;
            @(negedge clk);
        end while (!period_end && len < BUDGET);
        chk("chg_len", len, 100 * TK);
        chk("chg_high_old", high, 25 * TK);
        chk("chg_lat_before_pe", last_lat, 25);
        chk("chg_lat_at_pe", int'(duty_latched), 60);
        measure(len, high);
        chk("chg_high_new", high, 60 * TK);

        // en dropped at cnt=50 with duty=75
        duty = 7'd75;
        wait_pe("endrop");
        repeat (50 * TK) @(negedge clk);
        chk("endrop_pre_pwm", int'(pwm_out), 1);
        en = 1'b0;
        @(negedge clk);
        chk("endrop_pwm", int'(pwm_out), 0);
        chk("endrop_pe", int'(period_end), 0);
        repeat (5) @(negedge clk);
        chk("endrop_hold_pwm", int'(pwm_out), 0);
        en = 1'b1;
        clocks_to_pe(n);
        chk("reen_delay", n, TK);
        chk("reen_pwm", int'(pwm_out), 1);
        measure(len, high);
        chk("reen_len", len, 100 * TK);
        chk("reen_high", high, 75 * TK);

        // async reset at cnt=30 with pwm high
        repeat (30 * TK) @(negedge clk);
        chk("rst_mid_pre_pwm", int'(pwm_out), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pwm", int'(pwm_out), 0);
        chk("rst_mid_lat", int'(duty_latched), 0);
        chk("rst_mid_pe", int'(period_end), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clocks_to_pe(n);
        chk("rst_rel_delay", n, TK);
        chk("rst_rel_lat", int'(duty_latched), 75);
        measure(len, high);
        chk("rst_rel_len", len, 100 * TK);
        chk("rst_rel_high", high, 75 * TK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
